imm_gen_pipe: RTL

Parametrised, elastic immediate generator for the decode stage. It recognises every RV64I immediate format: I, S, B, U and J. It sign-extends the immediate to `XLEN` and carries the result through `PIPE_DEPTH` valid/ready register stages together with a caller tag. It replaces the single-cycle combinational generator, which covered only LD/SD/BEQ/ADDI. It sits between instruction fetch/IF-ID and the ID-EX register.

---
 rtl/imm_gen_pipe.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
// Elastic RV64I immediate generator: decodes I/S/B/U/J immediates and carries them through
// PIPE_DEPTH valid/ready stages. Define IMM_GEN_BYTE_OFFSET_EN for byte-offset B/J immediates.
module imm_gen_pipe #(
  parameter int XLEN       = 64,
  parameter int PIPE_DEPTH = 1,
  parameter int TAG_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  function automatic logic [XLEN-1:0] sext_imm(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  logic signed [31:0] dec_raw;
  logic [2:0]         dec_fmt;
  logic               dec_illegal;
  logic [XLEN-1:0]    dec_imm;

  // Stage 0 input: combinational decode of the incoming word
  always_comb begin
    dec_raw     = '0;
    dec_fmt     = FMT_NONE;
    dec_illegal = 1'b0;
    case (in_inst[6:0])
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR: begin
        dec_fmt = FMT_I;
        dec_raw = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      OP_STORE: begin
        dec_fmt = FMT_S;
        dec_raw = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      OP_BRANCH: begin
        dec_fmt = FMT_B;
`ifdef IMM_GEN_BYTE_OFFSET_EN
        dec_raw = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
`else
        dec_raw = {{20{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8]};
`endif
      end
      OP_LUI, OP_AUIPC: begin
        dec_fmt = FMT_U;
        dec_raw = {in_inst[31:12], 12'b0};
      end
      OP_JAL: begin
        dec_fmt = FMT_J;
`ifdef IMM_GEN_BYTE_OFFSET_EN
        dec_raw = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
`else
        dec_raw = {{12{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21]};
`endif
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign dec_imm = sext_imm(dec_raw);

  logic [PIPE_DEPTH-1:0] vld_q, vld_d, ill_q, ill_d, up_vld, up_ill;
  logic [XLEN-1:0]       imm_q [PIPE_DEPTH];
  logic [XLEN-1:0]       imm_d [PIPE_DEPTH];
  logic [XLEN-1:0]       up_imm [PIPE_DEPTH];
  logic [2:0]            fmt_q [PIPE_DEPTH];
  logic [2:0]            fmt_d [PIPE_DEPTH];
  logic [2:0]            up_fmt [PIPE_DEPTH];
  logic [TAG_W-1:0]      tag_q [PIPE_DEPTH];
  logic [TAG_W-1:0]      tag_d [PIPE_DEPTH];
  logic [TAG_W-1:0]      up_tag [PIPE_DEPTH];
  logic [PIPE_DEPTH:0]   rdy;

  // A stage can take new contents if it is empty or everything downstream drains this cycle
  always_comb begin : ready_chain
    logic r;
    r   = out_ready;
    rdy = '0;
    rdy[PIPE_DEPTH] = out_ready;
    for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
      r      = ~vld_q[k] | r;
      rdy[k] = r;
    end
  end

  assign in_ready = rdy[0] & ~flush;

  always_comb begin
    up_vld[0] = in_valid & in_ready;
    up_imm[0] = dec_imm;
    up_fmt[0] = dec_fmt;
    up_ill[0] = dec_illegal;
    up_tag[0] = in_tag;
    for (int k = 1; k < PIPE_DEPTH; k++) begin
      up_vld[k] = vld_q[k-1];
      up_imm[k] = imm_q[k-1];
      up_fmt[k] = fmt_q[k-1];
      up_ill[k] = ill_q[k-1];
      up_tag[k] = tag_q[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      vld_d[k] = flush ? 1'b0 : (rdy[k] ? up_vld[k] : vld_q[k]);
      imm_d[k] = imm_q[k];
      fmt_d[k] = fmt_q[k];
      ill_d[k] = ill_q[k];
      tag_d[k] = tag_q[k];
      if (rdy[k] && up_vld[k]) begin
        imm_d[k] = up_imm[k];
        fmt_d[k] = up_fmt[k];
        ill_d[k] = up_ill[k];
        tag_d[k] = up_tag[k];
      end
    end
  end

  // Stage registers; data only moves with a valid word so a stalled output stays put
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      ill_q <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        imm_q[k] <= '0;
        fmt_q[k] <= FMT_NONE;
        tag_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      ill_q <= ill_d;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        imm_q[k] <= imm_d[k];
        fmt_q[k] <= fmt_d[k];
        tag_q[k] <= tag_d[k];
      end
    end
  end

  assign out_valid   = vld_q[PIPE_DEPTH-1];
  assign out_imm     = imm_q[PIPE_DEPTH-1];
  assign out_fmt     = fmt_q[PIPE_DEPTH-1];
  assign out_illegal = ill_q[PIPE_DEPTH-1];
  assign out_tag     = tag_q[PIPE_DEPTH-1];

endmodule
